// File: rtl/ex_muldiv_if.sv
// Execute-stage <-> RV32M multiply/divide unit request/response bundle.
interface ex_muldiv_if;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  modport master (
    output start_i, op_i, rs1_i, rs2_i, flush_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, rs1_i, rs2_i, flush_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M unit: 32 radix-2 steps (shift-add multiply / restoring divide) then a one-cycle DONE pulse.
// Divide-by-zero and signed overflow bypass the iteration; busy_o stalls the pipeline while the unit is occupied.
module ex_muldiv (
  input logic         clk,
  input logic         reset_n,
  ex_muldiv_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] result_q;
  logic        done_q;

  function automatic logic neg_a_f(input logic [2:0] op, input logic [31:0] v);
    return v[31] & (op[2] ? ~op[0] : (op[1:0] != 2'b11));
  endfunction

  function automatic logic neg_b_f(input logic [2:0] op, input logic [31:0] v);
    return v[31] & (op[2] ? ~op[0] : ~op[1]);
  endfunction

  // Launch-side decode, taken straight from the request inputs.
  logic        start_ok;
  logic        in_div0;
  logic        in_ovf;
  logic [31:0] fast_res;
  logic [31:0] mag_a_in;
  logic [31:0] mag_b_in;

  always_comb begin
    start_ok = (state == IDLE) && bus.start_i && !bus.flush_i;
    in_div0  = bus.op_i[2] && (bus.rs2_i == 32'h0);
    in_ovf   = bus.op_i[2] && !bus.op_i[0] &&
               (bus.rs1_i == 32'h8000_0000) && (bus.rs2_i == 32'hFFFF_FFFF);
    if (in_div0)
      fast_res = bus.op_i[1] ? bus.rs1_i : 32'hFFFF_FFFF;
    else
      fast_res = bus.op_i[1] ? 32'h0 : 32'h8000_0000;
    mag_a_in = neg_a_f(bus.op_i, bus.rs1_i) ? -bus.rs1_i : bus.rs1_i;
    mag_b_in = neg_b_f(bus.op_i, bus.rs2_i) ? -bus.rs2_i : bus.rs2_i;
  end

  // One iteration step on the latched operands; hi/lo hold product or remainder/quotient.
  logic        neg_a;
  logic        neg_b;
  logic        neg_p;
  logic [31:0] m;
  logic [32:0] sum;
  logic [32:0] sh;
  logic [32:0] diff;
  logic [31:0] nhi;
  logic [31:0] nlo;
  logic [63:0] prod;
  logic [31:0] fin;

  always_comb begin
    neg_a = neg_a_f(op_q, rs1_q);
    neg_b = neg_b_f(op_q, rs2_q);
    neg_p = neg_a ^ neg_b;
    if (op_q[2])
      m = neg_b ? -rs2_q : rs2_q;
    else
      m = neg_a ? -rs1_q : rs1_q;
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : 33'h0);
    sh   = {hi, lo[31]};
    diff = sh - {1'b0, m};
    if (!op_q[2]) begin
      nhi = sum[32:1];
      nlo = {sum[0], lo[31:1]};
    end else if (!diff[32]) begin
      nhi = diff[31:0];
      nlo = {lo[30:0], 1'b1};
    end else begin
      nhi = sh[31:0];
      nlo = {lo[30:0], 1'b0};
    end
    prod = neg_p ? -{nhi, nlo} : {nhi, nlo};
    if (!op_q[2])
      fin = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
    else if (op_q[1])
      fin = neg_a ? -nhi : nhi;
    else
      fin = neg_p ? -nlo : nlo;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      op_q     <= 3'd0;
      rs1_q    <= 32'h0;
      rs2_q    <= 32'h0;
      hi       <= 32'h0;
      lo       <= 32'h0;
      result_q <= 32'h0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            op_q  <= bus.op_i;
            rs1_q <= bus.rs1_i;
            rs2_q <= bus.rs2_i;
            if (in_div0 || in_ovf) begin
              result_q <= fast_res;
              done_q   <= 1'b1;
              state    <= DONE;
            end else begin
              cnt   <= 5'd31;
              hi    <= 32'h0;
              lo    <= bus.op_i[2] ? mag_a_in : mag_b_in;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush_i) begin
            state <= IDLE;
          end else begin
            hi  <= nhi;
            lo  <= nlo;
            cnt <= cnt - 5'd1;
            if (cnt == 5'd0) begin
              result_q <= fin;
              done_q   <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o   = start_ok || (state == CALC);
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: latency, results, fast paths, flush and reset behaviour.
module tb_ex_muldiv;
  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  ex_muldiv_if bus ();
  ex_muldiv dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Drive a request for one cycle (cycle 0); returns positioned in cycle 1.
  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    tick();
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    #1;
    check({tag, "_busy_c0"}, {31'h0, bus.busy_o}, 32'h1);
    tick();
    bus.start_i = 1'b0;
    #1;
  endtask

  // Waits for done_o (bounded); optionally pulses a conflicting start at cycle 'poke'.
  task automatic wait_done(input int poke, output int lat, output logic busy_ok);
    lat     = 1;
    busy_ok = 1'b1;
    while (!bus.done_o && lat < 60) begin
      if (!bus.busy_o) busy_ok = 1'b0;
      bus.start_i = (lat == poke);
      if (lat == poke) begin
        bus.op_i  = DIVU;
        bus.rs1_i = 32'h1;
        bus.rs2_i = 32'h0;
      end
      tick();
      lat++;
    end
    bus.start_i = 1'b0;
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat, input int poke);
    int   lat;
    logic busy_ok;
    issue(tag, op, a, b);
    wait_done(poke, lat, busy_ok);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, bus.result_o, exp);
    check({tag, "_busy_done"}, {31'h0, bus.busy_o}, 32'h0);
    if (exp_lat > 1) check({tag, "_busy_calc"}, {31'h0, busy_ok}, 32'h1);
    tick();
    check({tag, "_pulse"}, {31'h0, bus.done_o}, 32'h0);
    check({tag, "_hold"}, bus.result_o, exp);
  endtask

  initial begin
    int   lat;
    logic busy_ok;
    int   seen;

    reset_n     = 1'b0;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op_i    = 3'd0;
    bus.rs1_i   = 32'h0;
    bus.rs2_i   = 32'h0;
    #1;
    check("rst_busy", {31'h0, bus.busy_o}, 32'h0);
    check("rst_done", {31'h0, bus.done_o}, 32'h0);
    check("rst_res", bus.result_o, 32'h0);
    tick();
    tick();
    reset_n = 1'b1;

    run_op("mul", MUL, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 33, 0);
    run_op("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    run_op("mulh", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 0);
    run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
    run_op("mulh_min", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    run_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
    run_op("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 33, 0);
    run_op("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
    run_op("rem_7_m2", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0);
    run_op("div_m8_m3", DIV, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2, 33, 0);
    run_op("rem_m8_m3", REM, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 33, 0);
    run_op("divu_max_1", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 0);
    run_op("divu_nonovf", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33, 0);
    run_op("divu_by0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("remu_by0", REMU, 32'd9, 32'd0, 32'd9, 1, 0);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);

    // A second start mid-CALC must neither restart nor disturb the running multiply.
    run_op("mul_ign", MUL, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 33, 5);

    // Flush mid-divide at cycle 10 with a stray start at cycle 5.
    issue("flush", DIV, 32'd100, 32'd7);
    for (int c = 1; c < 11; c++) begin
      bus.start_i = (c == 5);
      bus.flush_i = (c == 10);
      tick();
    end
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    #1;
    check("flush_busy", {31'h0, bus.busy_o}, 32'h0);
    check("flush_done", {31'h0, bus.done_o}, 32'h0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done_o || bus.busy_o) seen++;
      tick();
    end
    check("flush_quiet", seen, 0);
    check("flush_res_hold", bus.result_o, 32'hFFFF_FFD6);

    // Flush together with start in IDLE must not launch, not even a fast path.
    tick();
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    bus.op_i    = DIVU;
    bus.rs1_i   = 32'd5;
    bus.rs2_i   = 32'd0;
    #1;
    check("idle_flush_busy", {31'h0, bus.busy_o}, 32'h0);
    tick();
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    #1;
    check("idle_flush_done", {31'h0, bus.done_o}, 32'h0);
    check("idle_flush_busy2", {31'h0, bus.busy_o}, 32'h0);

    // Flush arriving in DONE keeps the visible pulse, then returns to IDLE.
    issue("flush_done", DIVU, 32'd100, 32'd7);
    wait_done(0, lat, busy_ok);
    check("fd_lat", lat, 33);
    bus.flush_i = 1'b1;
    #1;
    check("fd_done_vis", {31'h0, bus.done_o}, 32'h1);
    check("fd_res", bus.result_o, 32'd14);
    tick();
    bus.flush_i = 1'b0;
    #1;
    check("fd_done_after", {31'h0, bus.done_o}, 32'h0);
    check("fd_busy_after", {31'h0, bus.busy_o}, 32'h0);

    // Asynchronous reset at cycle 20 of a multiply.
    issue("rst_mid", MUL, 32'd7, 32'hFFFF_FFFA);
    for (int i = 0; i < 19; i++) tick();
    check("rst_mid_busy_pre", {31'h0, bus.busy_o}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'h0, bus.busy_o}, 32'h0);
    check("rst_mid_done", {31'h0, bus.done_o}, 32'h0);
    check("rst_mid_res", bus.result_o, 32'h0);
    tick();
    reset_n = 1'b1;
    run_op("mul_after_rst", MUL, 32'd3, 32'd5, 32'd15, 33, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
